// File: rtl/fetch_unit_if.sv
// Handshake bundle of the fetch stage: redirect, instruction-memory request/response
// and the downstream (instruction, PC) channel.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, in-order memory requests, a circular
// prefetch buffer and redirect handling that drops responses belonging to the old stream.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W:0]   SUM_ZERO = (CNT_W+1)'(0);
  localparam logic [CNT_W:0]   SUM_ONE  = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   DEPTH_V  = (CNT_W+1)'(DEPTH);

  logic [31:0]      fetch_pc_r;
  logic [31:0]      pc_r   [DEPTH];
  logic [31:0]      data_r [DEPTH];
  logic [DEPTH-1:0] filled_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W-1:0] fill_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] unfilled_r;
  logic [CNT_W-1:0] drop_cnt_r;

  logic             req_valid_s;
  logic             accept_s;
  logic             instr_valid_s;
  logic             pop_s;
  logic             fill_s;
  logic             drop_s;
  logic [CNT_W:0]   inflight_s;
  logic [CNT_W:0]   drop_sum_s;
  logic [CNT_W:0]   drop_next_s;

  // Per-cycle request, pop, fill and drop decisions.
  always_comb begin
    inflight_s    = {1'b0, count_r} + {1'b0, drop_cnt_r};
    // rst_n gating keeps the request channel quiet while the block is held in reset.
    req_valid_s   = rst_n && !bus.redirect_valid && (inflight_s < DEPTH_V);
    accept_s      = req_valid_s && bus.imem_req_ready;
    instr_valid_s = filled_r[head_r] && (count_r != CNT_ZERO) && !bus.redirect_valid;
    pop_s         = instr_valid_s && bus.instr_ready;
    drop_s        = bus.imem_rsp_valid && (drop_cnt_r != CNT_ZERO);
    fill_s        = bus.imem_rsp_valid && (drop_cnt_r == CNT_ZERO) && (unfilled_r != CNT_ZERO);
    drop_sum_s    = {1'b0, drop_cnt_r} + {1'b0, unfilled_r};
    if (bus.imem_rsp_valid && (drop_sum_s != SUM_ZERO)) begin
      drop_next_s = drop_sum_s - SUM_ONE;
    end else begin
      drop_next_s = drop_sum_s;
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fetch_pc_r;
  assign bus.instr_valid    = instr_valid_s;
  assign bus.instr          = data_r[head_r];
  assign bus.instr_pc       = pc_r[head_r];

  // Fetch address, buffer pointers and occupancy counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      head_r     <= PTR_W'(0);
      tail_r     <= PTR_W'(0);
      fill_ptr_r <= PTR_W'(0);
      count_r    <= CNT_ZERO;
      unfilled_r <= CNT_ZERO;
      drop_cnt_r <= CNT_ZERO;
    end else if (bus.redirect_valid) begin
      // Every outstanding unfilled entry becomes a response to throw away.
      fetch_pc_r <= {bus.redirect_pc[31:2], 2'b00};
      head_r     <= tail_r;
      fill_ptr_r <= tail_r;
      count_r    <= CNT_ZERO;
      unfilled_r <= CNT_ZERO;
      drop_cnt_r <= drop_next_s[CNT_W-1:0];
    end else begin
      if (accept_s) begin
        tail_r     <= tail_r + PTR_ONE;
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (fill_s) begin
        fill_ptr_r <= fill_ptr_r + PTR_ONE;
      end
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r - CNT_ONE;
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      case ({accept_s, fill_s})
        2'b10:   unfilled_r <= unfilled_r + CNT_ONE;
        2'b01:   unfilled_r <= unfilled_r - CNT_ONE;
        default: unfilled_r <= unfilled_r;
      endcase
    end
  end

  // Entry storage: allocation records the PC and clears filled, a kept response fills data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_r[i]   <= 32'h0000_0000;
        data_r[i] <= 32'h0000_0000;
      end
      filled_r <= {DEPTH{1'b0}};
    end else if (!bus.redirect_valid) begin
      if (accept_s) begin
        pc_r[tail_r]     <= fetch_pc_r;
        filled_r[tail_r] <= 1'b0;
      end
      if (fill_s) begin
        data_r[fill_ptr_r]   <= bus.imem_rsp_data;
        filled_r[fill_ptr_r] <= 1'b1;
      end
    end
  end
endmodule
